decoder_pipe: RTL and testbench

- Parametrised, pipelined successor to the 4-to-16 binary-to-one-hot decoder.
- Decodes an IN_W-bit binary code into NUM_OUT output bits in one of three modes: one-hot, thermometer or inverted one-hot.
- Flags out-of-range codes.
- Sits between a producer and a consumer using valid/ready handshakes on both sides.
- Provides full throughput through a 2-entry skid buffer.

---
 rtl/decoder_pkg.sv | 18 +
 rtl/decode_core.sv | 42 ++++
 rtl/decoder_pipe.sv | 116 +++++++++++
 tb/tb_decoder_pipe.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types for the pipelined binary decoder: decode modes and
// the skid-buffer occupancy states.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_INV    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } buf_state_e;

endpackage

// File: rtl/decode_core.sv
// Combinational decode of a binary code into one-hot, thermometer or
// inverted one-hot form, with an error flag for out-of-range codes and
// the reserved mode. Errored words are forced to all zeros.
module decode_core
  import decoder_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int NUM_OUT = 16
) (
  input  logic [IN_W-1:0]    binary_i,
  input  logic [1:0]         mode_i,
  output logic [NUM_OUT-1:0] word_o,
  output logic               err_o
);

  mode_e mode_s;
  logic  in_range;

  assign mode_s = mode_e'(mode_i);

  // One extra bit so NUM_OUT == 2**IN_W still compares correctly.
  assign in_range = ({1'b0, binary_i} < (IN_W+1)'(NUM_OUT));

  // Build the decoded word bit by bit; errors override everything.
  always_comb begin
    word_o = '0;
    err_o  = 1'b0;
    if (!in_range || mode_s == MODE_RSVD) begin
      err_o = 1'b1;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        case (mode_s)
          MODE_ONEHOT: word_o[i] = (binary_i == IN_W'(i));
          MODE_THERM:  word_o[i] = (IN_W'(i) <= binary_i);
          MODE_INV:    word_o[i] = (binary_i != IN_W'(i));
          default:     word_o[i] = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// Pipelined decoder with valid/ready on both sides. The decoded word is
// registered into an output register backed by a one-word skid register,
// so in_ready can be registered and still sustain one word per cycle.
//
// state | meaning
// EMPTY | no word held; accepting input
// ONE   | output register valid; accepting input
// FULL  | output and skid registers valid; input stalled
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int NUM_OUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    binary,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] one_hot,
  output logic               err
);

  buf_state_e         state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [NUM_OUT-1:0] out_word_q, out_word_d;
  logic               out_err_q, out_err_d;
  logic [NUM_OUT-1:0] skid_word_q, skid_word_d;
  logic               skid_err_q, skid_err_d;

  logic [NUM_OUT-1:0] dec_word;
  logic               dec_err;
  logic               in_xfer;
  logic               out_xfer;

  decode_core #(
    .IN_W    (IN_W),
    .NUM_OUT (NUM_OUT)
  ) u_decode_core (
    .binary_i (binary),
    .mode_i   (mode),
    .word_o   (dec_word),
    .err_o    (dec_err)
  );

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign one_hot   = out_word_q;
  assign err       = out_err_q;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid & out_ready;

  // Next occupancy state and register loads for the output/skid pair.
  always_comb begin
    state_d     = state_q;
    out_word_d  = out_word_q;
    out_err_d   = out_err_q;
    skid_word_d = skid_word_q;
    skid_err_d  = skid_err_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d    = ONE;
          out_word_d = dec_word;
          out_err_d  = dec_err;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          out_word_d = dec_word;
          out_err_d  = dec_err;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end else if (in_xfer) begin
          state_d     = FULL;
          skid_word_d = dec_word;
          skid_err_d  = dec_err;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d    = ONE;
          out_word_d = skid_word_q;
          out_err_d  = skid_err_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Registered ready: decided from where the buffer will be next cycle.
    in_ready_d = (state_d != FULL);
  end

  // State and data registers; reset drops any buffered words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_word_q  <= '0;
      out_err_q   <= 1'b0;
      skid_word_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_word_q  <= out_word_d;
      out_err_q   <= out_err_d;
      skid_word_q <= skid_word_d;
      skid_err_q  <= skid_err_d;
    end
  end

endmodule

// File: tb/tb_decoder_pipe.sv
module tb_decoder_pipe;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [3:0]  binary;
  logic [1:0]  mode;
  logic [15:0] one_hot;

  logic        in_valid10, in_ready10, out_valid10, out_ready10, err10;
  logic [3:0]  binary10;
  logic [1:0]  mode10;
  logic [9:0]  one_hot10;

  int n_checks = 0;
  int n_pass   = 0;

  decoder_pipe #(.IN_W(4), .NUM_OUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .binary    (binary),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .one_hot   (one_hot),
    .err       (err)
  );

  decoder_pipe #(.IN_W(4), .NUM_OUT(10)) dut10 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid10),
    .in_ready  (in_ready10),
    .binary    (binary10),
    .mode      (mode10),
    .out_valid (out_valid10),
    .out_ready (out_ready10),
    .one_hot   (one_hot10),
    .err       (err10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode for the 16-output instance: {err, word}.
  function automatic logic [16:0] ref_dec(input logic [3:0] k, input logic [1:0] m);
    logic [31:0] t;
    if (m == 2'b11) return {1'b1, 16'h0000};
    case (m)
      2'b00:   t = 32'h1 << k;
      2'b01:   t = (32'h2 << k) - 32'h1;
      default: t = ~(32'h1 << k);
    endcase
    return {1'b0, t[15:0]};
  endfunction

  logic [3:0]  codes [6];
  logic [15:0] exp_oh[6];
  logic [16:0] sb_q[$];
  logic [16:0] exp_e;

  initial begin
    codes  = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd12, 4'd15};
    exp_oh = '{16'h0001, 16'h0002, 16'h0004, 16'h0080, 16'h1000, 16'h8000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; binary = '0; mode = '0;
    in_valid10 = 1'b0; out_ready10 = 1'b1; binary10 = '0; mode10 = '0;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_one_hot", one_hot, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    step();
    check("in_ready_after_rst", in_ready, 1);

    // Streaming one-hot words with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; binary = codes[i]; mode = 2'b00;
      step();
      check("stream_valid", out_valid, 1);
      check("stream_word", one_hot, exp_oh[i]);
      check("stream_err", err, 0);
      check("stream_in_ready", in_ready, 1);
    end

    // Other modes with code 3.
    binary = 4'd3;
    mode = 2'b01; step();
    check("therm_word", one_hot, 16'h000F); check("therm_err", err, 0);
    mode = 2'b10; step();
    check("inv_word", one_hot, 16'hFFF7); check("inv_err", err, 0);
    mode = 2'b11; step();
    check("rsvd_word", one_hot, 16'h0000); check("rsvd_err", err, 1);
    in_valid = 1'b0; step();
    check("drained_valid", out_valid, 0);

    // Backpressure fills both entries, then drains in order.
    out_ready = 1'b0;
    in_valid = 1'b1; binary = 4'd5; mode = 2'b00; step();
    check("bp_first_word", one_hot, 16'h0020);
    check("bp_ready_one", in_ready, 1);
    binary = 4'd6; step();
    check("bp_full_ready", in_ready, 0);
    check("bp_full_word", one_hot, 16'h0020);
    in_valid = 1'b0; binary = 4'd1; step();
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_word", one_hot, 16'h0020);
    check("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp_release_first", one_hot, 16'h0020);
    step();
    check("bp_second_valid", out_valid, 1);
    check("bp_second_word", one_hot, 16'h0040);
    check("bp_second_ready", in_ready, 1);
    step();
    check("bp_empty", out_valid, 0);

    // Reset while FULL discards both words.
    out_ready = 1'b0;
    in_valid = 1'b1; binary = 4'd8; step();
    binary = 4'd9; step();
    check("pre_rst_full", in_ready, 0);
    in_valid = 1'b0; rst_n = 1'b0; step();
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_word", one_hot, 0);
    rst_n = 1'b1; out_ready = 1'b1; step();
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    step();
    check("post_rst_no_stale", out_valid, 0);

    // NUM_OUT=10: out-of-range and top legal code.
    in_valid10 = 1'b1; binary10 = 4'd12; mode10 = 2'b00; step();
    check("n10_oor_valid", out_valid10, 1);
    check("n10_oor_word", one_hot10, 10'h000);
    check("n10_oor_err", err10, 1);
    binary10 = 4'd9; mode10 = 2'b01; step();
    check("n10_therm_word", one_hot10, 10'h3FF);
    check("n10_therm_err", err10, 0);
    mode10 = 2'b10; step();
    check("n10_inv_word", one_hot10, 10'h1FF);
    in_valid10 = 1'b0; step();

    // Random valid/ready against a scoreboard.
    begin
      int sent = 0, rcvd = 0, cyc = 0;
      while (rcvd < 1000 && cyc < 20000) begin
        in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
        out_ready = $urandom_range(0, 1) == 1;
        binary    = 4'($urandom_range(0, 15));
        mode      = 2'($urandom_range(0, 3));
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("rand_unexpected_word", out_valid, 0);
          end else begin
            exp_e = sb_q.pop_front();
            check("rand_word", one_hot, exp_e[15:0]);
            check("rand_err", err, exp_e[16]);
          end
          rcvd++;
        end
        if (in_valid && in_ready) begin
          sb_q.push_back(ref_dec(binary, mode));
          sent++;
        end
        step();
        cyc++;
      end
      check("rand_count", rcvd, 1000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
